ring_output_arbiter: RTL and testbench
======================================

# ring_output_arbiter

Round-robin arbiter and output stage for one outgoing ring link of the bidirectional ring router. It shares the link between two single-entry (depth-1) input buffers: the ring pass-through buffer and the local PE injection buffer. It drains the winning buffer through its read enable, decrements the hop count of forwarded ring flits, and holds the flit in a one-entry output register under a send/ready handshake.

## Interface
Parameters:
- WIDTH, 64, flit width in bits
- HOP_MSB, 55, MSB of hop-count field
- HOP_LSB, 48, LSB of hop-count field (field width HW = HOP_MSB-HOP_LSB+1 = 8)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high
- ringFull  input  1  ring pass-through buffer holds a flit
- ringData  input  WIDTH  ring buffer dataOut
- ringRdEnable  output  1  read (pop) strobe to ring buffer
- peFull  input  1  PE injection buffer holds a flit
- peData  input  WIDTH  PE buffer dataOut
- peRdEnable  output  1  read strobe to PE buffer
- so  output  1  output flit valid (send out)
- ri  input  1  downstream ready (ready in)
- dataOut  output  WIDTH  output flit
- hopErr  output  1  one-cycle pulse: ring flit arrived with hop = 0

## Operation
- Output register: outReg (WIDTH), outValid (drives so). dataOut = outReg.
- load = ~reset & (~outValid | ri): output slot is free this cycle, or is being drained this cycle.
- Requests: reqRing = ringFull, reqPe = peFull.
- Priority pointer prio (1 bit; 0 = ring first, 1 = PE first).
- Grant, combinational, only when load = 1:
  - one requester active: that requester wins;
  - both active: prio picks the winner;
  - none active: no grant.
- Winner's RdEnable = 1 for that cycle. Loser's RdEnable = 0. Both are 0 whenever load = 0 or reset = 1.
- On grant, at the clock edge:
  - outReg <= winner's data. For a ring winner, the hop field is replaced by hop-1; all other bits pass unchanged.
  - outValid <= 1.
  - prio <= 1 if ring won, 0 if PE won. The loser has priority next time.
- Hop arithmetic: unsigned HW bits. If a ring flit has hop = 0, the field saturates at 0 (no wrap) and hopErr pulses in the next cycle. PE flits are never modified.
- If load = 1 and there is no grant: outValid <= 0 when ri = 1 (drained). Otherwise outValid holds.
- If load = 0 (outValid = 1, ri = 0): outReg, outValid and prio hold; no RdEnable is asserted.
- Transfer happens on any cycle with so = 1 and ri = 1.

## Timing
- Reset values: so = 0, dataOut = 0, hopErr = 0, prio = 0, ringRdEnable = peRdEnable = 0.
- Reset asserted mid-operation discards the held flit at the next edge. RdEnables are forced low in the reset cycle, so no buffer is popped.
- Latency: a buffer full in cycle T, with load = 1, is granted in T. The flit appears on so/dataOut in T+1.
- The buffer's full flag clears in T+1 from its own rdEnable. The arbiter does not re-request the same flit because the flag has dropped.
- Throughput: one flit per cycle sustained while ri = 1. Under continuous dual requests, grants alternate ring, PE, ring, ...
- Back-pressure: with ri = 0 and so = 1, so and dataOut are stable until the accepting cycle.
- Simultaneous drain and refill: if ri = 1 and a grant occurs in the same cycle, outReg is overwritten with the new flit and so stays 1 (no bubble).
- The path ri -> RdEnable is combinational (single level).

## Structure
- Shared NoC package holds the flit field constants: HOP_MSB/HOP_LSB, the VC/direction bit positions, and the flit WIDTH default.
- Natural sub-module: rr_arbiter2. It is a 2-requester round-robin with enable input, grant outputs and an internal pointer updated on grant. The datapath mux, hop decrement and output register stay in the top.

## Test plan
- Reset: drive reset for 2 cycles with both buffers full.
  - Required: no RdEnable asserted; so = 0, dataOut = 0.
  - After release with ri = 1: ring is granted first.
- Single ring flit with hop = 5, ri = 1.
  - Required: ringRdEnable pulses 1 cycle; next cycle so = 1 and dataOut has hop = 4 and all other bits equal.
- Both full every cycle with ri = 1 (buffers refilled each cycle), 6 cycles.
  - Required: grants alternate R,P,R,P,R,P; so stays 1; PE flits unchanged.
- Back-pressure: so = 1, hold ri = 0 for 3 cycles with a PE flit pending.
  - Required: dataOut stable, no RdEnable.
  - On ri = 1: PE is granted that same cycle, and its flit appears the next cycle with no bubble.
- Ring flit with hop = 0.
  - Required: output hop = 0 and hopErr = 1 for exactly one cycle.
  - A following flit with hop = 1 gives output hop = 0 and hopErr = 0.
- Reset asserted while so = 1, ri = 0, and ringFull = 1.
  - Required: next cycle so = 0, prio = 0, ring buffer not popped.

Source files
------------

// File: rtl/ring_output_arbiter_pkg.sv
// ring_output_arbiter_pkg: shared NoC flit field positions and default flit width.
package ring_output_arbiter_pkg;
    localparam int FLIT_W  = 64;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
    localparam int VC_BIT  = 56;
    localparam int DIR_BIT = 57;
endpackage

// File: rtl/ring_output_arbiter_rr_arbiter2.sv
// ring_output_arbiter_rr_arbiter2: two-requester round-robin; bit 0 = ring, bit 1 = PE.
module ring_output_arbiter_rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic r_prio;
    assign o_gnt = ~i_en ? 2'b00 : (&i_req) ? (r_prio ? 2'b10 : 2'b01) : i_req;
    // The loser of the last grant gets priority next time
    always_ff @(posedge clk) begin
        if (reset)
            r_prio <= 1'b0;
        else if (|o_gnt)
            r_prio <= o_gnt[0];
    end
endmodule

// File: rtl/ring_output_arbiter.sv
// ring_output_arbiter: shares one ring link between the ring pass-through and PE injection
// buffers, decrementing the hop count of forwarded ring flits into a one-entry output register.
module ring_output_arbiter
    import ring_output_arbiter_pkg::*;
#(
    parameter int WIDTH   = FLIT_W,
    parameter int HOP_MSB = ring_output_arbiter_pkg::HOP_MSB,
    parameter int HOP_LSB = ring_output_arbiter_pkg::HOP_LSB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ringFull,
    input  logic [WIDTH-1:0] ringData,
    output logic             ringRdEnable,
    input  logic             peFull,
    input  logic [WIDTH-1:0] peData,
    output logic             peRdEnable,
    output logic             so,
    input  logic             ri,
    output logic [WIDTH-1:0] dataOut,
    output logic             hopErr
);
    localparam int HW = HOP_MSB - HOP_LSB + 1;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic             r_hop_err;
    logic             w_load;
    logic [1:0]       w_gnt;
    logic [HW-1:0]    w_hop;
    logic             w_hop_zero;
    logic [WIDTH-1:0] w_ring_fwd;
    assign w_load     = ~reset & (~r_valid | ri);
    assign w_hop      = ringData[HOP_MSB:HOP_LSB];
    assign w_hop_zero = (w_hop == '0);
    ring_output_arbiter_rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_load),
        .i_req ({peFull, ringFull}),
        .o_gnt (w_gnt)
    );
    // Hop count saturates at zero; an expired flit is flagged rather than wrapped
    always_comb begin
        w_ring_fwd                  = ringData;
        w_ring_fwd[HOP_MSB:HOP_LSB] = w_hop_zero ? w_hop : w_hop - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_hop_err <= 1'b0;
        end else begin
            r_hop_err <= w_gnt[0] & w_hop_zero;
            if (|w_gnt) begin
                r_out   <= w_gnt[0] ? w_ring_fwd : peData;
                r_valid <= 1'b1;
            end else if (ri) begin
                r_valid <= 1'b0;
            end
        end
    end
    assign ringRdEnable = w_gnt[0];
    assign peRdEnable   = w_gnt[1];
    assign so           = r_valid;
    assign dataOut      = r_out;
    assign hopErr       = r_hop_err;
endmodule

// File: tb/tb_ring_output_arbiter.sv
// tb_ring_output_arbiter: directed-vector bench for the ring output arbiter.
module tb_ring_output_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        ringFull, peFull, ri;
    logic [63:0] ringData, peData;
    logic        ringRdEnable, peRdEnable, so, hopErr;
    logic [63:0] dataOut;
    logic [63:0] hold;
    int          n_checks = 0;
    int          n_err = 0;

    ring_output_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .ringFull     (ringFull),
        .ringData     (ringData),
        .ringRdEnable (ringRdEnable),
        .peFull       (peFull),
        .peData       (peData),
        .peRdEnable   (peRdEnable),
        .so           (so),
        .ri           (ri),
        .dataOut      (dataOut),
        .hopErr       (hopErr)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ri = 1'b1; ringFull = 1'b1; peFull = 1'b1;
        ringData = {8'hA5, 8'h05, 48'h1234_5678_9ABC};
        peData   = {16'hBEEF, 48'h0000_0000_0001};
        cyc();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_ringRd", ringRdEnable, 0);
            chk("rst_peRd", peRdEnable, 0);
            cyc();
            chk("rst_so", so, 0);
            chk("rst_data", dataOut, 0);
            chk("rst_hopErr", hopErr, 0);
        end
        // release: ring wins first, hop 5 -> 4
        reset = 1'b0;
        #1;
        chk("first_ringRd", ringRdEnable, 1);
        chk("first_peRd", peRdEnable, 0);
        cyc();
        chk("hop5_so", so, 1);
        chk("hop5_data", dataOut, {8'hA5, 8'h04, 48'h1234_5678_9ABC});
        chk("hop5_hopErr", hopErr, 0);
        // idle: output drains
        ringFull = 1'b0; peFull = 1'b0;
        #1;
        chk("idle_ringRd", ringRdEnable, 0);
        chk("idle_peRd", peRdEnable, 0);
        cyc();
        chk("idle_so", so, 0);
        // lone PE flit, returns priority to ring
        peFull = 1'b1; peData = {16'hBEEF, 48'h0000_0000_0002};
        #1;
        chk("pe1_peRd", peRdEnable, 1);
        cyc();
        chk("pe1_data", dataOut, {16'hBEEF, 48'h0000_0000_0002});
        // both full for 6 cycles: R,P,R,P,R,P
        for (int i = 0; i < 6; i++) begin
            ringFull = 1'b1; peFull = 1'b1;
            ringData = {8'hC0, 8'h20 + 8'(i), 48'(i)};
            peData   = {16'hBEEF, 48'(i + 16)};
            #1;
            chk("alt_ringRd", ringRdEnable, (i % 2 == 0));
            chk("alt_peRd", peRdEnable, (i % 2 == 1));
            cyc();
            chk("alt_so", so, 1);
            chk("alt_data", dataOut, (i % 2 == 0) ? {8'hC0, 8'h1F + 8'(i), 48'(i)}
                                                  : {16'hBEEF, 48'(i + 16)});
        end
        // back-pressure with a PE flit pending
        hold = {16'hBEEF, 48'(21)};
        ri = 1'b0; ringFull = 1'b0; peFull = 1'b1;
        peData = {16'h5A5A, 48'h0000_0000_00AA};
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ringRd", ringRdEnable, 0);
            chk("bp_peRd", peRdEnable, 0);
            cyc();
            chk("bp_so", so, 1);
            chk("bp_data", dataOut, hold);
        end
        ri = 1'b1;
        #1;
        chk("bp_rel_peRd", peRdEnable, 1);
        chk("bp_rel_ringRd", ringRdEnable, 0);
        cyc();
        chk("bp_rel_so", so, 1);
        chk("bp_rel_data", dataOut, {16'h5A5A, 48'h0000_0000_00AA});
        // hop = 0 saturates and flags once
        peFull = 1'b0; ringFull = 1'b1;
        ringData = {8'h77, 8'h00, 48'h0000_0000_FACE};
        #1;
        chk("hop0_ringRd", ringRdEnable, 1);
        cyc();
        chk("hop0_data", dataOut, {8'h77, 8'h00, 48'h0000_0000_FACE});
        chk("hop0_hopErr", hopErr, 1);
        ringData = {8'h77, 8'h01, 48'h0000_0000_F00D};
        cyc();
        chk("hop1_data", dataOut, {8'h77, 8'h00, 48'h0000_0000_F00D});
        chk("hop1_hopErr", hopErr, 0);
        chk("hop1_so", so, 1);
        // reset while holding a flit under back-pressure; ring last won so prio was 1
        ri = 1'b0; reset = 1'b1; ringFull = 1'b1; peFull = 1'b1;
        #1;
        chk("midrst_ringRd", ringRdEnable, 0);
        chk("midrst_peRd", peRdEnable, 0);
        cyc();
        chk("midrst_so", so, 0);
        chk("midrst_data", dataOut, 0);
        reset = 1'b0; ri = 1'b1;
        ringData = {8'h11, 8'h03, 48'h0000_0000_0033};
        #1;
        chk("midrst_prio_ringRd", ringRdEnable, 1);
        chk("midrst_prio_peRd", peRdEnable, 0);
        cyc();
        chk("midrst_after_data", dataOut, {8'h11, 8'h02, 48'h0000_0000_0033});
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
